// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the 7-segment scan display: active-low segment
// patterns and the hex glyph table.
package seg7_scan_display_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         DP_BIT    = 7;

    // Entry n holds the active-low glyph for hex digit n (index 0 is rightmost).
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low 7-segment pattern, decimal point off.
module seg7_hex_decoder
    import seg7_scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    always_comb begin
        seg         = HEX_SEG[nibble];
        seg[DP_BIT] = 1'b1;
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed hex display of a latched data word on a common-anode
// 7-segment bank, with tear-free frame-boundary updates, blanking and blink.
module seg7_scan_display
    import seg7_scan_display_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DIGITS       = WIDTH / 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              data_we,
    input  logic              halt,
    input  logic              blank_lz,
    output logic [7:0]        SEG,
    output logic [DIGITS-1:0] AN,
    output logic              frame_done
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]  prescaler;
    logic [IDX_W-1:0]  idx;
    logic [BLK_W-1:0]  blink_cnt;
    logic              blink_ph;
    logic [WIDTH-1:0]  pending;
    logic              pend_flag;
    logic [WIDTH-1:0]  shadow;

    logic              tick;
    logic              boundary;
    logic [IDX_W-1:0]  idx_nxt;
    logic [WIDTH-1:0]  shadow_nxt;
    logic              blink_ph_nxt;
    logic [WIDTH-1:0]  upper;
    logic [3:0]        nibble;
    logic              lead_zero;
    logic              digit_off;
    logic [DIGITS-1:0] an_nxt;
    logic [7:0]        seg_dec;

    assign tick       = (prescaler == PRE_LAST);
    assign boundary   = tick && (idx == IDX_LAST);
    assign frame_done = boundary;

    // The output registers load from next-state idx/shadow/phase so the
    // digit lit after a boundary already shows the newly committed word.
    always_comb begin
        idx_nxt      = idx;
        shadow_nxt   = shadow;
        blink_ph_nxt = blink_ph;
        if (tick) begin
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
        if (boundary) begin
            if (data_we) begin
                shadow_nxt = data_in;
            end else if (pend_flag) begin
                shadow_nxt = pending;
            end
            if (blink_cnt == BLK_LAST) begin
                blink_ph_nxt = ~blink_ph;
            end
        end
    end

    always_comb begin
        upper     = shadow_nxt >> {idx_nxt, 2'b00};
        nibble    = upper[3:0];
        lead_zero = (upper == '0);
        digit_off = (blank_lz && (idx_nxt != '0) && lead_zero) || (halt && blink_ph_nxt);
        an_nxt    = digit_off ? '1 : ~(DIGITS'(1) << idx_nxt);
    end

    seg7_hex_decoder u_dec (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler <= '0;
            idx       <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            idx       <= idx_nxt;
        end
    end

    // data_we is a single-cycle strobe with no back-pressure: every strobe is
    // accepted, and the newest word before (or at) a boundary is the one shown.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending   <= '0;
            pend_flag <= 1'b0;
            shadow    <= '0;
        end else begin
            shadow <= shadow_nxt;
            if (boundary) begin
                pend_flag <= 1'b0;
            end else if (data_we) begin
                pending   <= data_in;
                pend_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            if (boundary) begin
                blink_cnt <= (blink_cnt == BLK_LAST) ? '0 : blink_cnt + 1'b1;
            end
            blink_ph <= blink_ph_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            SEG <= SEG_BLANK;
            AN  <= '1;
        end else if (tick) begin
            SEG <= digit_off ? SEG_BLANK : seg_dec;
            AN  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed, table-driven bench for seg7_scan_display with a short scan
// divider and blink period so whole frames are cheap to observe.
module tb_seg7_scan_display;

    localparam int WIDTH        = 32;
    localparam int DIGITS       = 8;
    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [WIDTH-1:0]  data_in = '0;
    logic              data_we = 1'b0;
    logic              halt = 1'b0;
    logic              blank_lz = 1'b0;
    logic [7:0]        SEG;
    logic [DIGITS-1:0] AN;
    logic              frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int frames_k = 0;

    logic [7:0] got_seg [8];
    logic [7:0] got_an  [8];

    typedef struct {
        logic [31:0]     data;
        logic            blz;
        logic [7:0]      mask;
        logic [7:0][7:0] segs;
    } vec_t;

    vec_t vecs [8];

    seg7_scan_display #(
        .WIDTH        (WIDTH),
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_we    (data_we),
        .halt       (halt),
        .blank_lz   (blank_lz),
        .SEG        (SEG),
        .AN         (AN),
        .frame_done (frame_done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Boundaries since reset; drives the expected blink phase.
    always @(posedge clk or negedge rst) begin
        if (!rst) frames_k <= 0;
        else if (frame_done) frames_k <= frames_k + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic strobe(input logic [31:0] d);
        @(negedge clk);
        data_in = d;
        data_we = 1'b1;
        @(negedge clk);
        data_we = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 200);
        if (!frame_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: got no frame_done expected one within 200 cycles");
        end
    endtask

    // Called at the negedge where frame_done is high; samples digits 0..7.
    task automatic capture_frame();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                @(negedge clk);
                data_we = 1'b0;
            end else begin
                repeat (SCAN_DIV) @(negedge clk);
            end
            got_seg[i] = SEG;
            got_an[i]  = AN;
        end
    endtask

    function automatic logic [7:0] an_lit(input int i);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << i);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int bad;
        int seen_one;
        logic dark;
        logic [7:0] exp_an;

        vecs[0] = '{32'h1234ABCD, 1'b0, 8'h00, {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h88, 8'h83, 8'hC6, 8'hA1}};
        vecs[1] = '{32'h000000A5, 1'b1, 8'hFC, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h88, 8'h92}};
        vecs[2] = '{32'h00000000, 1'b1, 8'hFE, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[3] = '{32'h0F00F000, 1'b1, 8'h80, {8'hFF, 8'h8E, 8'hC0, 8'hC0, 8'h8E, 8'hC0, 8'hC0, 8'hC0}};
        vecs[4] = '{32'h89ABCDEF, 1'b0, 8'h00, {8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E}};
        vecs[5] = '{32'h01234567, 1'b1, 8'h80, {8'hFF, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8}};
        vecs[6] = '{32'hDEADBEEF, 1'b0, 8'h00, {8'hA1, 8'h86, 8'h88, 8'hA1, 8'h83, 8'h86, 8'h86, 8'h8E}};
        vecs[7] = '{32'h00000000, 1'b0, 8'h00, {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0}};

        // Reset state and first digit timing.
        repeat (3) @(negedge clk);
        check("rst_seg", SEG, 8'hFF);
        check("rst_an", AN, 8'hFF);
        check("rst_frame_done", frame_done, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_tick_an", AN, 8'hFF);
        @(negedge clk);
        check("first_an", AN, 8'hFD);
        check("first_seg", SEG, 8'hC0);
        n = 4;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 200);
        check("first_frame_done_cycle", n, 31);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 200);
        check("frame_period", n, 32);

        // Mid-frame write must not show until the next boundary.
        repeat (5) @(negedge clk);
        data_in = 32'h1234ABCD;
        data_we = 1'b1;
        @(negedge clk);
        data_we = 1'b0;
        bad = 0;
        n = 0;
        while (!frame_done && n < 200) begin
            if (SEG !== 8'hC0) bad++;
            @(negedge clk);
            n++;
        end
        check("no_tear_samples", bad, 0);
        check("no_tear_reached_boundary", frame_done, 1'b1);
        @(negedge clk);
        check("tear_digit0_seg", SEG, 8'hA1);
        check("tear_digit0_an", AN, 8'hFE);

        // Table of words.
        for (int v = 0; v < 8; v++) begin
            blank_lz = vecs[v].blz;
            strobe(vecs[v].data);
            wait_frame();
            capture_frame();
            for (int i = 0; i < 8; i++) begin
                exp_an = vecs[v].mask[i] ? 8'hFF : an_lit(i);
                check($sformatf("v%0d_seg%0d", v, i), got_seg[i], vecs[v].segs[i]);
                check($sformatf("v%0d_an%0d", v, i), got_an[i], exp_an);
            end
        end

        // Write in the exact boundary cycle overrides an earlier in-frame write.
        blank_lz = 1'b0;
        wait_frame();
        repeat (4) @(negedge clk);
        strobe(32'h11111111);
        seen_one = 0;
        repeat (26) begin
            @(negedge clk);
            if (SEG === 8'hF9) seen_one++;
        end
        check("boundary_align", frame_done, 1'b1);
        data_in = 32'hFFFFFFFF;
        data_we = 1'b1;
        capture_frame();
        check("stale_never_shown", seen_one, 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bnd_seg%0d", i), got_seg[i], 8'h8E);
            check($sformatf("bnd_an%0d", i), got_an[i], an_lit(i));
        end
        wait_frame();
        capture_frame();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bnd_next_seg%0d", i), got_seg[i], 8'h8E);
        end

        // Blink while halted: phase flips every BLINK_FRAMES boundaries.
        halt = 1'b1;
        for (int f = 0; f < 6; f++) begin
            wait_frame();
            @(negedge clk);
            dark = ((frames_k / BLINK_FRAMES) % 2) == 1;
            check($sformatf("blink%0d_an", f), AN, dark ? 8'hFF : 8'hFE);
            check($sformatf("blink%0d_seg", f), SEG, dark ? 8'hFF : 8'h8E);
        end
        dark = 1'b0;
        for (int f = 0; f < 6 && !dark; f++) begin
            wait_frame();
            @(negedge clk);
            dark = ((frames_k / BLINK_FRAMES) % 2) == 1;
        end
        check("release_found_dark", dark, 1'b1);
        check("release_dark_an", AN, 8'hFF);
        @(negedge clk);
        halt = 1'b0;
        @(negedge clk);
        check("release_hold1_an", AN, 8'hFF);
        @(negedge clk);
        check("release_hold2_an", AN, 8'hFF);
        @(negedge clk);
        check("release_tick_an", AN, 8'hFD);
        check("release_tick_seg", SEG, 8'h8E);

        // Asynchronous mid-frame reset drops pending data.
        strobe(32'h12345678);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("async_rst_seg", SEG, 8'hFF);
        check("async_rst_an", AN, 8'hFF);
        check("async_rst_frame_done", frame_done, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_an", AN, 8'hFD);
        check("post_rst_seg", SEG, 8'hC0);
        wait_frame();
        capture_frame();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("post_rst_seg%0d", i), got_seg[i], 8'hC0);
            check($sformatf("post_rst_an%0d", i), got_an[i], an_lit(i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
